// File: rtl/fnd_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : fnd_seg_decoder
// Description : Two-digit 7-segment pattern decoder. Samples a strobed,
//               time-multiplexed active-low segment bus, decodes each pattern
//               to a BCD code (0..9, 4'hF = blank) and commits a digit only
//               after it has been seen on STABLE_CNT consecutive strobes for
//               that digit. Illegal patterns set a sticky per-digit error.
// Ports       : i_Clk     - clock, rising edge
//               i_Rst     - synchronous reset, active-high
//               i_Seg     - segment pattern, active-low, bit 6 = g .. bit 0 = a
//               i_Strobe  - i_Seg / i_Sel valid this cycle
//               i_Sel     - digit addressed by the strobe (0 = A, 1 = B)
//               i_ErrClr  - clears both sticky error flags
//               o_NumA/B  - committed code per digit
//               o_ValidA/B- committed code is a decimal digit
//               o_ErrA/B  - sticky illegal-pattern flags
//               o_Upd     - one-cycle pulse when a committed digit changes
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_seg_decoder #(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_Seg,
    input  logic       i_Strobe,
    input  logic       i_Sel,
    input  logic       i_ErrClr,
    output logic [3:0] o_NumA,
    output logic [3:0] o_NumB,
    output logic       o_ValidA,
    output logic       o_ValidB,
    output logic       o_ErrA,
    output logic       o_ErrB,
    output logic       o_Upd
);

    localparam logic [CNT_W-1:0] c_stable   = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [3:0]       c_blank    = 4'hF;
    // Never produced by the decoder, so the next legal strobe after an
    // illegal one always starts a fresh streak.
    localparam logic [3:0]       c_bad_cand = 4'hE;

    // Per-digit state, index 0 = digit A, index 1 = digit B.
    logic [3:0]       r_cand  [2];
    logic [CNT_W-1:0] r_cnt   [2];
    logic [3:0]       r_num   [2];
    logic             r_valid [2];
    logic             r_err   [2];
    logic             r_upd;

    logic [3:0]       w_code;
    logic             w_legal;
    logic [3:0]       w_cand_sel;
    logic [CNT_W-1:0] w_cnt_sel;
    logic [3:0]       w_num_sel;
    logic [CNT_W-1:0] w_new_cnt;
    logic             w_commit;

    // Pattern decode
    always_comb begin
        w_code  = c_blank;
        w_legal = 1'b1;
        case (i_Seg)
            7'b1000000: w_code = 4'd0;
            7'b1111001: w_code = 4'd1;
            7'b0100100: w_code = 4'd2;
            7'b0110000: w_code = 4'd3;
            7'b0011001: w_code = 4'd4;
            7'b0010010: w_code = 4'd5;
            7'b0000010: w_code = 4'd6;
            7'b1111000: w_code = 4'd7;
            7'b0000000: w_code = 4'd8;
            7'b0010000: w_code = 4'd9;
            7'b1111111: w_code = c_blank;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_cand_sel = r_cand[i_Sel];
    assign w_cnt_sel  = r_cnt[i_Sel];
    assign w_num_sel  = r_num[i_Sel];

    // Streak length including the current strobe, saturating at STABLE_CNT.
    always_comb begin
        w_new_cnt = c_cnt_one;
        if (w_code == w_cand_sel) begin
            if (w_cnt_sel >= c_stable) begin
                w_new_cnt = c_stable;
            end else begin
                w_new_cnt = w_cnt_sel + c_cnt_one;
            end
        end
    end

    // A re-confirmed identical value is not a commit, so no o_Upd pulse.
    assign w_commit = i_Strobe && w_legal && (w_new_cnt >= c_stable) &&
                      (w_code != w_num_sel);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cand[0]  <= c_blank;
            r_cand[1]  <= c_blank;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
            r_num[0]   <= c_blank;
            r_num[1]   <= c_blank;
            r_valid[0] <= 1'b0;
            r_valid[1] <= 1'b0;
            r_err[0]   <= 1'b0;
            r_err[1]   <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (i_ErrClr) begin
                r_err[0] <= 1'b0;
                r_err[1] <= 1'b0;
            end
            if (i_Strobe) begin
                if (w_legal) begin
                    r_cand[i_Sel] <= w_code;
                    r_cnt[i_Sel]  <= w_new_cnt;
                    if (w_commit) begin
                        r_num[i_Sel]   <= w_code;
                        r_valid[i_Sel] <= (w_code <= 4'd9);
                        r_upd          <= 1'b1;
                    end
                end else begin
                    // Placed after the clear so a coincident set wins.
                    r_err[i_Sel]  <= 1'b1;
                    r_cand[i_Sel] <= c_bad_cand;
                    r_cnt[i_Sel]  <= '0;
                end
            end
        end
    end

    assign o_NumA   = r_num[0];
    assign o_NumB   = r_num[1];
    assign o_ValidA = r_valid[0];
    assign o_ValidB = r_valid[1];
    assign o_ErrA   = r_err[0];
    assign o_ErrB   = r_err[1];
    assign o_Upd    = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_fnd_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_seg_decoder
// Description : Self-checking bench for fnd_seg_decoder. Two instances
//               (STABLE_CNT = 3 and STABLE_CNT = 1) share one stimulus
//               stream; a behavioural model per instance predicts every
//               output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_seg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic       strobe;
    logic       sel;
    logic       errclr;

    logic [3:0] num_a   [2];
    logic [3:0] num_b   [2];
    logic       valid_a [2];
    logic       valid_b [2];
    logic       err_a   [2];
    logic       err_b   [2];
    logic       upd     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fnd_seg_decoder #(.STABLE_CNT(3), .CNT_W(4)) u_dut3 (
        .i_Clk(clk), .i_Rst(rst), .i_Seg(seg), .i_Strobe(strobe), .i_Sel(sel),
        .i_ErrClr(errclr), .o_NumA(num_a[0]), .o_NumB(num_b[0]),
        .o_ValidA(valid_a[0]), .o_ValidB(valid_b[0]), .o_ErrA(err_a[0]),
        .o_ErrB(err_b[0]), .o_Upd(upd[0])
    );

    fnd_seg_decoder #(.STABLE_CNT(1), .CNT_W(4)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Seg(seg), .i_Strobe(strobe), .i_Sel(sel),
        .i_ErrClr(errclr), .o_NumA(num_a[1]), .o_NumB(num_b[1]),
        .o_ValidA(valid_a[1]), .o_ValidB(valid_b[1]), .o_ErrA(err_a[1]),
        .o_ErrB(err_b[1]), .o_Upd(upd[1])
    );

    // Segment patterns indexed by the code they represent; entry 10 = blank.
    logic [6:0] pat [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b1111111};

    // Reference model state: [instance][digit]
    int stab [2] = '{3, 1};
    int m_cand [2][2];
    int m_run  [2][2];
    int m_num  [2][2];
    bit m_err  [2][2];
    bit m_upd  [2];

    function automatic int decode(logic [6:0] p);
        for (int i = 0; i < 11; i++)
            if (pat[i] == p) return (i == 10) ? 15 : i;
        return -1;
    endfunction

    task automatic model_step();
        int c;
        int run;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    m_cand[k][d] = 15;
                    m_run[k][d]  = 0;
                    m_num[k][d]  = 15;
                    m_err[k][d]  = 1'b0;
                end
                m_upd[k] = 1'b0;
            end else begin
                m_upd[k] = 1'b0;
                if (errclr) begin
                    m_err[k][0] = 1'b0;
                    m_err[k][1] = 1'b0;
                end
                if (strobe) begin
                    c = decode(seg);
                    if (c < 0) begin
                        m_err[k][sel]  = 1'b1;
                        m_cand[k][sel] = -1;
                        m_run[k][sel]  = 0;
                    end else begin
                        run = (c == m_cand[k][sel]) ? m_run[k][sel] + 1 : 1;
                        if (run > stab[k]) run = stab[k];
                        m_cand[k][sel] = c;
                        m_run[k][sel]  = run;
                        if (run == stab[k] && c != m_num[k][sel]) begin
                            m_num[k][sel] = c;
                            m_upd[k]      = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, int k, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("num_a",   k, num_a[k],          4'(m_num[k][0]));
            chk("num_b",   k, num_b[k],          4'(m_num[k][1]));
            chk("valid_a", k, {3'b0, valid_a[k]}, {3'b0, m_num[k][0] <= 9});
            chk("valid_b", k, {3'b0, valid_b[k]}, {3'b0, m_num[k][1] <= 9});
            chk("err_a",   k, {3'b0, err_a[k]},   {3'b0, m_err[k][0]});
            chk("err_b",   k, {3'b0, err_b[k]},   {3'b0, m_err[k][1]});
            chk("upd",     k, {3'b0, upd[k]},     {3'b0, m_upd[k]});
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, check.
    task automatic drive(bit st, bit s, logic [6:0] sg, bit clr, bit r);
        strobe = st;
        sel    = s;
        seg    = sg;
        errclr = clr;
        rst    = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic stb(bit s, logic [6:0] sg);
        drive(1'b1, s, sg, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'b1111111, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] last_seg [2];
        bit s;

        // Reset, then three matching strobes of "2" on A.
        drive(1'b0, 1'b0, 7'b1111111, 1'b0, 1'b1);
        chk("rst_num_a", 0, num_a[0], 4'hF);
        chk("rst_upd",   0, {3'b0, upd[0]}, 4'h0);
        stb(1'b0, 7'b0100100);
        chk("t1_upd_first_s1", 1, {3'b0, upd[1]}, 4'h1);
        stb(1'b0, 7'b0100100);
        chk("t1_no_commit", 0, num_a[0], 4'hF);
        stb(1'b0, 7'b0100100);
        chk("t1_num_a", 0, num_a[0], 4'h2);
        chk("t1_upd",   0, {3'b0, upd[0]}, 4'h1);
        idle();
        chk("t1_upd_drop", 0, {3'b0, upd[0]}, 4'h0);

        // Interleaved A = 3, B = 9.
        for (int i = 0; i < 3; i++) begin
            stb(1'b0, 7'b0110000);
            stb(1'b1, 7'b0010000);
        end
        chk("t2_num_a", 0, num_a[0], 4'h3);
        chk("t2_num_b", 0, num_b[0], 4'h9);

        // Illegal pattern breaks an A streak of 4.
        stb(1'b0, 7'b0011001);
        stb(1'b0, 7'b0011001);
        stb(1'b0, 7'b1011001);
        chk("t3_err_a", 0, {3'b0, err_a[0]}, 4'h1);
        stb(1'b0, 7'b0011001);
        stb(1'b0, 7'b0011001);
        chk("t3_no_commit", 0, num_a[0], 4'h3);

        // Commit 7, hold it (saturation), then blank.
        for (int i = 0; i < 8; i++) stb(1'b0, 7'b1111000);
        chk("t4_num_a", 0, num_a[0], 4'h7);
        chk("t4_no_repulse", 0, {3'b0, upd[0]}, 4'h0);
        for (int i = 0; i < 3; i++) stb(1'b0, 7'b1111111);
        chk("t4_blank", 0, num_a[0], 4'hF);
        chk("t4_valid", 0, {3'b0, valid_a[0]}, 4'h0);

        // Error clear racing an illegal strobe on B.
        stb(1'b1, 7'b0000001);
        drive(1'b1, 1'b1, 7'b0000001, 1'b1, 1'b0);
        chk("t5_err_b_set_wins", 0, {3'b0, err_b[0]}, 4'h1);
        chk("t5_err_a_cleared",  0, {3'b0, err_a[0]}, 4'h0);
        drive(1'b0, 1'b0, 7'b1111111, 1'b1, 1'b0);
        chk("t5_err_b_clr", 0, {3'b0, err_b[0]}, 4'h0);

        // Reset in the middle of a streak.
        stb(1'b0, 7'b0000010);
        stb(1'b0, 7'b0000010);
        drive(1'b0, 1'b0, 7'b1111111, 1'b0, 1'b1);
        chk("t6_rst_num_b", 0, num_b[0], 4'hF);
        stb(1'b0, 7'b0000010);
        chk("t6_no_commit", 0, num_a[0], 4'hF);
        stb(1'b0, 7'b0000010);
        stb(1'b0, 7'b0000010);
        chk("t6_num_a", 0, num_a[0], 4'h6);

        // Randomised traffic with sticky per-digit patterns to build streaks.
        last_seg[0] = pat[0];
        last_seg[1] = pat[0];
        for (int n = 0; n < 3000; n++) begin
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 4) == 0) last_seg[s] = 7'($urandom);
                else last_seg[s] = pat[$urandom_range(0, 10)];
            end
            drive($urandom_range(0, 9) < 7, s, last_seg[s],
                  $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fnd_seg_decoder.md
Name: fnd_seg_decoder

Overview:
- Opposite end of the team's two-digit 7-segment encoder: takes active-low segment patterns and recovers the BCD digits.
- Samples a strobed, time-multiplexed segment bus (digit A / digit B) and decodes each pattern to a 4-bit code.
- Commits a digit only after it is seen stable for STABLE_CNT consecutive strobes; flags illegal patterns.
- Used as a display-path loopback checker and for reading the segment outputs of external counters.

Parameters:
STABLE_CNT, 3, consecutive identical strobed samples needed before a digit commits; legal range 1..15
CNT_W, 4, width of the per-digit streak counter; must hold STABLE_CNT

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst  input  1  synchronous reset, active-high
i_Seg  input  7  segment pattern, active-low, bit 6 = g ... bit 0 = a
i_Strobe  input  1  i_Seg/i_Sel valid this cycle
i_Sel  input  1  digit addressed by the strobe: 0 = A, 1 = B
i_ErrClr  input  1  clears both sticky error flags
o_NumA  output  4  committed code for digit A: 0..9, or 4'hF = blank
o_NumB  output  4  committed code for digit B, same encoding
o_ValidA  output  1  o_NumA holds a decimal digit (0..9)
o_ValidB  output  1  o_NumB holds a decimal digit (0..9)
o_ErrA  output  1  sticky: illegal pattern seen on digit A
o_ErrB  output  1  sticky: illegal pattern seen on digit B
o_Upd  output  1  one-cycle pulse: a committed digit changed this cycle

Behaviour:
- Decode table (combinational, i_Seg -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
  - 1111111->4'hF (blank)
  - Any other pattern is illegal.
- Per-digit state d in {A, B}: cand_d (4 bit), cnt_d (CNT_W bit), committed o_Num_d.
- Cycles with i_Strobe=0: i_Seg and i_Sel are ignored and no state changes, except o_Upd returns to 0 and i_ErrClr is still honoured.
- On a strobe for digit d with a legal code c:
  - new_cnt = (c == cand_d) ? min(cnt_d+1, STABLE_CNT) : 1.
  - cand_d <= c; cnt_d <= new_cnt.
  - If new_cnt >= STABLE_CNT and c != o_Num_d, commit on the next edge: o_Num_d <= c, o_Valid_d <= (c <= 9), o_Upd <= 1.
- On a strobe for digit d with an illegal pattern:
  - o_Err_d <= 1; cand_d <= 4'hE; cnt_d <= 0; no commit.
  - The streak restarts from 1 on the next legal strobe.
- Latency: committed outputs and o_Upd are registered. They change on the clock edge that samples the qualifying strobe, so they are visible the cycle after i_Strobe.
- o_Upd: high for exactly one cycle per commit. A re-confirmed identical value gives no pulse. Strobes address one digit, so at most one commit per cycle.
- STABLE_CNT=1: every legal strobe whose code differs from the committed value commits immediately.
- Saturation: cnt_d never exceeds STABLE_CNT; an indefinitely stable value does not wrap.
- Streak independence: A and B streaks are independent, so interleaved strobes A,B,A,B count separately per digit.
- Errors:
  - o_Err_d is cleared only by i_ErrClr or i_Rst.
  - If i_ErrClr and an illegal strobe on digit d coincide, the set wins: o_Err_d = 1. The other digit's flag clears.
- Reset (synchronous, i_Rst=1 at an edge):
  - o_NumA = o_NumB = 4'hF; o_ValidA = o_ValidB = 0; o_ErrA = o_ErrB = 0; o_Upd = 0.
  - cand = 4'hF; cnt = 0.
  - Reset overrides any strobe in the same cycle. A streak in progress is discarded.
- Blank is a legal committed value: o_Valid_d = 0, o_Err_d unaffected.

Test Plan:
- Reset, then 3 strobes on A with i_Seg=0100100 -> o_NumA=2, o_ValidA=1, single o_Upd pulse the cycle after the 3rd strobe; no change after strobes 1 and 2.
- Interleave A: 0110000 and B: 0010000, 3 each alternating -> o_NumA=3, o_NumB=9, two separate o_Upd pulses, after the 3rd A strobe and the 3rd B strobe.
- A streak 0011001 x2, then 1011001 (illegal), then 0011001 x2 -> o_ErrA=1 after the illegal strobe; no commit, since the streak restarted.
- Committed A=7 (1111000), 5 more strobes of 1111000 -> o_Upd stays 0 and the counter saturates; then 1111111 x3 -> o_NumA=4'hF, o_ValidA=0, one o_Upd.
- o_ErrB=1, assert i_ErrClr in the same cycle as an illegal B strobe -> o_ErrB stays 1; i_ErrClr alone next cycle -> o_ErrB=0.
- i_Rst pulsed after 2 of 3 matching strobes of 0000010 on A -> outputs at reset values; 1 further strobe gives no commit; 3 further strobes give o_NumA=6.
